// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared defaults, select type and one-hot decoder for regfile_mp.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int          DEFAULT_DW    = 32;
  localparam int          DEFAULT_DEPTH = 32;
  localparam int          DEFAULT_AW    = $clog2(DEFAULT_DEPTH);
  localparam int          ZERO_IDX      = 0;
  localparam int unsigned DEC_MAX       = 1024;

  typedef logic [DEFAULT_AW-1:0] reg_sel_t;

  // Wide one-hot; callers size-cast the result down to their DEPTH.
  function automatic logic [DEC_MAX-1:0] onehot_dec(input int unsigned sel);
    onehot_dec = {{(DEC_MAX-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
// Module  : regfile_rd_port
// Purpose : One combinational read port: mux, zero-register mask, optional
//           write-through forwarding (REGFILE_BYPASS_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DW       = DEFAULT_DW,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]    sel,
  input  logic [DW-1:0]    regs [DEPTH],
  input  logic [DEPTH-1:0] busy,
  input  logic             fwd_en,
  input  logic [AW-1:0]    w_sel,
  input  logic [DW-1:0]    w_data,
  input  logic             issue_same,
  output logic [DW-1:0]    data,
  output logic             busy_out
);

  logic is_zero;
  logic [DW-1:0] stored_data;
  logic stored_busy;

  assign is_zero     = (ZERO_REG != 0) && (sel == AW'(ZERO_IDX));
  assign stored_data = is_zero ? '0 : regs[sel];
  assign stored_busy = is_zero ? 1'b0 : busy[sel];

`ifdef REGFILE_BYPASS_EN
  logic hit;

  // A same-cycle issue to the register being written re-marks it busy.
  assign hit      = fwd_en && (sel == w_sel) && !is_zero;
  assign data     = hit ? w_data : stored_data;
  assign busy_out = hit ? issue_same : stored_busy;
`else
  logic unused_bypass;

  assign unused_bypass = ^{fwd_en, w_sel, w_data, issue_same};
  assign data          = stored_data;
  assign busy_out      = stored_busy;
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module  : regfile_mp
// Purpose : Multi-port register file with pending-write scoreboard.
//           Optional macro REGFILE_BYPASS_EN enables write-through forwarding.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DEFAULT_DW,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 w_en,
  input  logic [AW-1:0]        w_sel,
  input  logic [DW-1:0]        w_data,
  input  logic [NUM_RD*AW-1:0] r_sel,
  output logic [NUM_RD*DW-1:0] r_data,
  output logic [NUM_RD-1:0]    r_busy,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_sel,
  output logic [DEPTH-1:0]     busy_vec
);

  localparam logic [DEPTH-1:0] ZERO_MASK =
      (ZERO_REG != 0) ? (DEPTH'(1) << ZERO_IDX) : '0;

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] wr_dec;
  logic [DEPTH-1:0] iss_dec;
  logic             fwd_en;
  logic             issue_same;

  assign wr_dec  = DEPTH'(onehot_dec(32'(w_sel)))     & ~ZERO_MASK & {DEPTH{w_en}};
  assign iss_dec = DEPTH'(onehot_dec(32'(issue_sel))) & ~ZERO_MASK & {DEPTH{issue_en}};

  // Gating with reset_n keeps forwarded values off r_data while in reset.
  assign fwd_en     = w_en && reset_n;
  assign issue_same = issue_en && reset_n && (issue_sel == w_sel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
      busy <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) begin
        if (wr_dec[n]) regs[n] <= w_data;
      end
      // Issue takes priority over a same-cycle write-back clear.
      busy <= (busy & ~wr_dec) | iss_dec;
    end
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .sel        (r_sel[i*AW +: AW]),
      .regs       (regs),
      .busy       (busy),
      .fwd_en     (fwd_en),
      .w_sel      (w_sel),
      .w_data     (w_data),
      .issue_same (issue_same),
      .data       (r_data[i*DW +: DW]),
      .busy_out   (r_busy[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module  : tb_regfile_mp
// Purpose : Directed, table-driven self-checking bench for regfile_mp.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        w_en;
  reg_sel_t    w_sel;
  logic [31:0] w_data;
  logic [9:0]  r_sel;
  logic [63:0] r_data;
  logic [1:0]  r_busy;
  logic        issue_en;
  reg_sel_t    issue_sel;
  logic [31:0] busy_vec;

  int n_applied = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .w_en      (w_en),
    .w_sel     (w_sel),
    .w_data    (w_data),
    .r_sel     (r_sel),
    .r_data    (r_data),
    .r_busy    (r_busy),
    .issue_en  (issue_en),
    .issue_sel (issue_sel),
    .busy_vec  (busy_vec)
  );

  typedef struct {
    logic        we;
    reg_sel_t    ws;
    logic [31:0] wd;
    logic        ie;
    reg_sel_t    is;
    reg_sel_t    rs0;
    reg_sel_t    rs1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [31:0] bv;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input reg_sel_t ws, input logic [31:0] wd,
                       input logic ie, input reg_sel_t is, input reg_sel_t rs0,
                       input reg_sel_t rs1);
    w_en = we; w_sel = ws; w_data = wd;
    issue_en = ie; issue_sel = is;
    r_sel = {rs1, rs0};
  endtask

  task automatic check_all(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                           input logic b0, input logic b1, input logic [31:0] bv);
    chk({tag, " r_data0"}, r_data[31:0], d0);
    chk({tag, " r_data1"}, r_data[63:32], d1);
    chk({tag, " r_busy0"}, 32'(r_busy[0]), 32'(b0));
    chk({tag, " r_busy1"}, 32'(r_busy[1]), 32'(b1));
    chk({tag, " busy_vec"}, busy_vec, bv);
  endtask

  initial begin
    // we ws wd ie is rs0 rs1 | d0 d1 b0 b1 bv ; expectations before the committing edge
    tbl[0]  = '{0, 0, 0,            0, 0, 0, 31, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 1,  BP ? 32'hDEADBEEF : 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0,            0, 0, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    tbl[3]  = '{1, 0, 32'h12345678, 1, 0, 0, 5,  0, 32'hDEADBEEF, 0, 0, 0};
    tbl[4]  = '{0, 0, 0,            0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0,            1, 7, 7, 7,  0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0,            0, 0, 7, 5,  0, 32'hDEADBEEF, 1, 0, 32'h80};
    tbl[7]  = '{1, 7, 32'hA5A5A5A5, 0, 0, 7, 7,  BP ? 32'hA5A5A5A5 : 0, BP ? 32'hA5A5A5A5 : 0,
                !BP, !BP, 32'h80};
    tbl[8]  = '{0, 0, 0,            0, 0, 7, 7,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0};
    tbl[9]  = '{1, 9, 32'h1,        1, 9, 9, 7,  BP ? 32'h1 : 0, 32'hA5A5A5A5, BP, 0, 0};
    tbl[10] = '{0, 0, 0,            0, 0, 9, 9,  32'h1, 32'h1, 1, 1, 32'h200};
    tbl[11] = '{0, 0, 0,            1, 9, 9, 0,  32'h1, 0, 1, 0, 32'h200};
    tbl[12] = '{1, 9, 32'h2,        0, 0, 9, 9,  BP ? 32'h2 : 32'h1, BP ? 32'h2 : 32'h1,
                !BP, !BP, 32'h200};
    tbl[13] = '{0, 0, 0,            0, 0, 9, 0,  32'h2, 0, 0, 0, 0};
    tbl[14] = '{1, 3, 32'h55,       0, 0, 3, 3,  BP ? 32'h55 : 0, BP ? 32'h55 : 0, 0, 0, 0};
    tbl[15] = '{0, 0, 0,            0, 0, 3, 9,  32'h55, 32'h2, 0, 0, 0};
    tbl[16] = '{1, 31, 32'hFFFFFFFF, 1, 2, 31, 2, BP ? 32'hFFFFFFFF : 0, 0, 0, 0, 0};
    tbl[17] = '{0, 0, 0,            0, 0, 31, 2, 32'hFFFFFFFF, 0, 0, 1, 32'h4};
    tbl[18] = '{1, 2, 32'h00C0FFEE, 0, 0, 2, 2,  BP ? 32'h00C0FFEE : 0, BP ? 32'h00C0FFEE : 0,
                !BP, !BP, 32'h4};
    tbl[19] = '{0, 0, 0,            0, 0, 2, 5,  32'h00C0FFEE, 32'hDEADBEEF, 0, 0, 0};

    // Reset with a write and issue pending: both must be discarded.
    reset_n = 1'b0;
    drive(1, 4, 32'h11111111, 1, 4, 4, 4);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 4, 4);
    @(negedge clk);
    check_all("post_reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].we, tbl[i].ws, tbl[i].wd, tbl[i].ie, tbl[i].is, tbl[i].rs0, tbl[i].rs1);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].d0, tbl[i].d1, tbl[i].b0, tbl[i].b1, tbl[i].bv);
    end

    // Mark reg 4 busy, then assert reset mid-cycle while writing reg 5.
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 4, 5, 4);
    @(posedge clk); #1;
    drive(1, 5, 32'h77777777, 0, 0, 5, 4);
    @(negedge clk);
    check_all("pre_async", BP ? 32'h77777777 : 32'hDEADBEEF, 0, 0, 1, 32'h10);
    #1 reset_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 5, 3);
    @(negedge clk);
    check_all("after_async", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
